// File: rtl/data_memory_lat.sv
// Line-wide backing memory for the data cache with a fixed access latency and one outstanding request.
// Define DMEM_BYTE_MASK_EN to make writes honour the per-byte mask; otherwise every write replaces the full line.
module data_memory_lat #(
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LATENCY = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic                write_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   data_i,
    input  logic [DATA_W/8-1:0] mask_i,
    output logic                ready_o,
    output logic                ack_o,
    output logic                err_o,
    output logic [DATA_W-1:0]   data_o
);

    localparam int unsigned NB     = DATA_W / 8;
    localparam int unsigned OFS_W  = $clog2(DATA_W / 8);
    localparam int unsigned LINE_W = ADDR_W - OFS_W;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    nxt_cnt;
    logic                nxt_ack;
    logic                nxt_err;
    logic [DATA_W-1:0]   nxt_data;

    logic [LINE_W-1:0]   req_line;
    logic [DATA_W-1:0]   req_data;
    logic [NB-1:0]       req_be;
    logic                req_write;

    logic                accept_c;
    logic                mem_we_c;
    logic                in_range_c;
    logic [IDX_W-1:0]    idx_c;
    logic [NB-1:0]       be_in_c;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Byte offset within a line never selects anything; the whole line moves at once
    logic unused_ofs;
    assign unused_ofs = ^addr_i[OFS_W-1:0];

`ifdef DMEM_BYTE_MASK_EN
    assign be_in_c = mask_i;
`else
    logic unused_mask;
    assign unused_mask = ^mask_i;
    assign be_in_c     = {NB{1'b1}};
`endif

    assign in_range_c = (req_line < LINE_W'(DEPTH));
    assign idx_c      = req_line[IDX_W-1:0];

    // Next-state, counter and output-value decode
    always_comb begin
        next_state = state;
        nxt_cnt    = cnt;
        nxt_ack    = 1'b0;
        nxt_err    = 1'b0;
        nxt_data   = data_o;
        accept_c   = 1'b0;
        mem_we_c   = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable_i) begin
                    accept_c   = 1'b1;
                    nxt_cnt    = CNT_W'(1);
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == CNT_W'(LATENCY)) begin
                    next_state = S_ACK;
                    nxt_ack    = 1'b1;
                    if (!in_range_c) begin
                        nxt_err  = 1'b1;
                        nxt_data = '0;
                    end else if (req_write) begin
                        mem_we_c = 1'b1;
                    end else begin
                        nxt_data = mem[idx_c];
                    end
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end
            S_ACK: begin
                next_state = S_IDLE;
                nxt_cnt    = '0;
            end
            default: begin
                next_state = S_IDLE;
                nxt_cnt    = '0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= S_IDLE;
            cnt     <= '0;
            ready_o <= 1'b1;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            data_o  <= '0;
        end else begin
            state   <= next_state;
            cnt     <= nxt_cnt;
            ready_o <= (next_state == S_IDLE);
            ack_o   <= nxt_ack;
            err_o   <= nxt_err;
            data_o  <= nxt_data;
        end
    end

    // Request capture: only these copies are used after accept
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            req_line  <= '0;
            req_data  <= '0;
            req_be    <= '0;
            req_write <= 1'b0;
        end else if (accept_c) begin
            req_line  <= addr_i[ADDR_W-1:OFS_W];
            req_data  <= data_i;
            req_be    <= be_in_c;
            req_write <= write_i;
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk_i) begin
        if (mem_we_c) begin
            for (int k = 0; k < int'(NB); k++) begin
                if (req_be[k]) begin
                    mem[idx_c][8*k +: 8] <= req_data[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_lat.sv
// Randomised scoreboard bench for data_memory_lat: a timing/contents reference model predicts each ack,
// and a negedge monitor compares ready/ack/err/data against it.
module tb_data_memory_lat;

    localparam int unsigned DW    = 256;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned AW    = 32;
    localparam int unsigned LAT   = 8;
    localparam int unsigned NB    = DW / 8;
    localparam int unsigned OFS   = $clog2(NB);

    logic          clk_i    = 1'b0;
    logic          rst_i    = 1'b0;
    logic          enable_i = 1'b0;
    logic          write_i  = 1'b0;
    logic [AW-1:0] addr_i   = '0;
    logic [DW-1:0] data_i   = '0;
    logic [NB-1:0] mask_i   = '0;
    logic          ready_o;
    logic          ack_o;
    logic          err_o;
    logic [DW-1:0] data_o;

    data_memory_lat #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .ADDR_W (AW),
        .LATENCY(LAT)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .enable_i(enable_i),
        .write_i (write_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .mask_i  (mask_i),
        .ready_o (ready_o),
        .ack_o   (ack_o),
        .err_o   (err_o),
        .data_o  (data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0] data;
        logic [NB-1:0] keep;
        bit            err;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] mem_m   [int];
    logic [NB-1:0] known_m [int];
    logic [DW-1:0] last_data = '0;
    logic [NB-1:0] last_keep = '1;

    bit            pend      = 1'b0;
    bit            pend_wr   = 1'b0;
    bit            exp_ready = 1'b1;
    bit            exp_ack   = 1'b0;
    bit            started   = 1'b0;
    int            due       = 0;
    int            cyc       = 0;
    int            n_acc     = 0;
    int            pend_line = 0;
    logic [DW-1:0] pend_data = '0;
    logic [NB-1:0] pend_be   = '0;

    int total = 0;
    int bad   = 0;

    function automatic logic [DW-1:0] expand(input logic [NB-1:0] k);
        logic [DW-1:0] r;
        for (int b = 0; b < int'(NB); b++) r[8*b +: 8] = {8{k[b]}};
        return r;
    endfunction

    task automatic checkb(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0b expected %0b", name, cyc, act, exp);
        end
    endtask

    task automatic checkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic void model_commit();
        logic [DW-1:0] t;
        logic [NB-1:0] kn;
        t  = mem_m.exists(pend_line)   ? mem_m[pend_line]   : '0;
        kn = known_m.exists(pend_line) ? known_m[pend_line] : '0;
        for (int b = 0; b < int'(NB); b++) begin
            if (pend_be[b]) begin
                t[8*b +: 8] = pend_data[8*b +: 8];
                kn[b]       = 1'b1;
            end
        end
        mem_m[pend_line]   = t;
        known_m[pend_line] = kn;
    endfunction

    function automatic void model_accept();
        exp_t e;
        int   line;
        line    = int'(addr_i >> OFS);
        n_acc++;
        pend    = 1'b1;
        pend_wr = 1'b0;
        due     = cyc + int'(LAT);
        exp_ready = 1'b0;
        if (line >= int'(DEPTH)) begin
            e.data    = '0;
            e.keep    = '1;
            e.err     = 1'b1;
            last_data = '0;
            last_keep = '1;
        end else if (write_i) begin
            e.data    = last_data;
            e.keep    = last_keep;
            e.err     = 1'b0;
            pend_wr   = 1'b1;
            pend_line = line;
            pend_data = data_i;
`ifdef DMEM_BYTE_MASK_EN
            pend_be   = mask_i;
`else
            pend_be   = '1;
`endif
        end else begin
            e.data    = mem_m.exists(line)   ? mem_m[line]   : '0;
            e.keep    = known_m.exists(line) ? known_m[line] : '0;
            e.err     = 1'b0;
            last_data = e.data;
            last_keep = e.keep;
        end
        q.push_back(e);
    endfunction

    // Reference model: one request in flight, ack LAT edges after accept, idle one edge later
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pend      = 1'b0;
            pend_wr   = 1'b0;
            exp_ready = 1'b1;
            exp_ack   = 1'b0;
            last_data = '0;
            last_keep = '1;
            q.delete();
        end else begin
            cyc++;
            exp_ack = 1'b0;
            if (pend && cyc == due) begin
                exp_ack = 1'b1;
                if (pend_wr) model_commit();
            end else if (pend && cyc == due + 1) begin
                pend      = 1'b0;
                exp_ready = 1'b1;
            end else if (!pend && enable_i) begin
                model_accept();
            end
        end
    end

    // Monitor: compares DUT outputs against the model every cycle
    always @(negedge clk_i) begin
        if (rst_i && started) begin
            exp_t e;
            checkb("ready", ready_o, exp_ready);
            checkb("ack", ack_o, exp_ack);
            if (exp_ack) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard at cycle %0d: got ack expected empty queue", cyc);
                end else begin
                    e = q.pop_front();
                    checkb("err", err_o, e.err);
                    checkd("data", data_o & expand(e.keep), e.data & expand(e.keep));
                end
            end else begin
                checkb("err_idle", err_o, 1'b0);
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 4 * int'(LAT) + 10; i++) begin
            if (!pend) break;
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [NB-1:0] m, input bit scramble, input bit wait_done);
        int start;
        start    = n_acc;
        enable_i = 1'b1;
        write_i  = wr;
        addr_i   = a;
        data_i   = d;
        mask_i   = m;
        for (int i = 0; i < 2 * int'(LAT) + 10; i++) begin
            @(posedge clk_i);
            #1;
            if (n_acc != start) break;
        end
        if (scramble) begin
            // Requests offered while busy must be ignored and must not disturb the latched one
            write_i = 1'b1;
            addr_i  = AW'(32'h0A0);
            data_i  = {8{$urandom}};
            mask_i  = '1;
            repeat (2) begin
                @(posedge clk_i);
                #1;
            end
        end
        enable_i = 1'b0;
        addr_i   = {$urandom};
        data_i   = {8{$urandom}};
        if (wait_done) wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rnd;
        logic [AW-1:0] a;
        int            line;
        int            r;

        repeat (3) @(posedge clk_i);
        #1;
        rst_i   = 1'b1;
        started = 1'b1;
        @(negedge clk_i);
        checkd("reset_data", data_o, '0);
        checkb("reset_ready", ready_o, 1'b1);

        // Write then read a known pattern
        issue(1'b1, AW'(32'h40), {32{8'hA5}}, '1, 1'b0, 1'b1);
        issue(1'b0, AW'(32'h40), {8{$urandom}}, '0, 1'b0, 1'b1);

        // Byte-masked write of 0xFF over byte 0, then read back
        issue(1'b1, AW'(32'h40), {32{8'hFF}}, NB'(1), 1'b0, 1'b1);
        issue(1'b0, AW'(32'h40), '0, '0, 1'b0, 1'b1);

        // Back-to-back reads with enable held high
        @(negedge clk_i);
        enable_i = 1'b1;
        write_i  = 1'b0;
        addr_i   = AW'(32'h40);
        repeat (3 * (LAT + 2) + 1) @(posedge clk_i);
        #1;
        enable_i = 1'b0;
        wait_idle();

        // Inputs changed while busy: line 5 must keep its value, line 3 gets the latched data
        issue(1'b1, AW'(32'h0A0), {8{32'h5555_0005}}, '1, 1'b0, 1'b1);
        issue(1'b1, AW'(32'h060), {8{32'h3333_0003}}, '1, 1'b1, 1'b1);
        issue(1'b0, AW'(32'h060), '0, '0, 1'b1, 1'b1);
        issue(1'b0, AW'(32'h0A0), '0, '0, 1'b0, 1'b1);

        // Out-of-range index: error ack, no aliasing onto line 0
        issue(1'b1, AW'(0), {8{32'h0000_C0DE}}, '1, 1'b0, 1'b1);
        issue(1'b0, AW'(DEPTH) << OFS, '0, '0, 1'b0, 1'b1);
        issue(1'b1, AW'(DEPTH) << OFS, '1, '1, 1'b0, 1'b1);
        issue(1'b0, AW'(0), '0, '0, 1'b0, 1'b1);

        // Reset three cycles into a write: write dropped, old value survives
        issue(1'b1, AW'(32'h060), {8{32'hDEAD_BEEF}}, '1, 1'b0, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        checkb("rst_mid_ready", ready_o, 1'b1);
        checkb("rst_mid_ack", ack_o, 1'b0);
        checkd("rst_mid_data", data_o, '0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        issue(1'b0, AW'(32'h060), '0, '0, 1'b0, 1'b1);

        // Random traffic over a small working set plus out-of-range indices
        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      line = int'(DEPTH) + int'($urandom_range(0, 100));
            else if (r == 1) line = int'($urandom_range(DEPTH, 32'h07FF_FFFF));
            else             line = int'($urandom_range(0, 7));
            a   = (AW'(line) << OFS) | AW'($urandom_range(0, NB - 1));
            rnd = {8{$urandom}};
            issue(1'($urandom_range(0, 1)), a, rnd, NB'($urandom), 1'b0, 1'b1);
        end

        wait_idle();
        repeat (3) @(negedge clk_i);
        checkb("queue_empty", q.size() == 0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
